// File: rtl/sd_block_sequencer.sv
// rtl/sd_block_sequencer.sv - SD block read sequencer with first-word fall-through byte FIFO
module sd_block_sequencer #(
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned ADDR_STEP  = 512,
    parameter int unsigned TIMEOUT    = 2_000_000
) (
    input  logic        clk_25mhz,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_blocks,
    input  logic        abort,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    input  logic        rd_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] blocks_done,
    output logic        overflow,
    output logic        timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SPACE_MAX = CW'(FIFO_DEPTH - 512);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_REQUEST,
        S_READING,
        S_DRAIN_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [15:0]   num_blocks_q, num_blocks_d;
    logic [15:0]   blocks_done_q, blocks_done_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;
    logic [9:0]    byte_cnt_q, byte_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          in_block;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic [15:0]   blocks_next;

    // A full FIFO still takes a byte when the consumer frees a slot on the same edge.
    always_comb begin
        in_block = (state_q == S_READING) || (state_q == S_DRAIN_ABORT);
        pop      = (count_q != '0) && out_ready;
        push     = in_block && rd_valid;
        push_ok  = push && ((count_q != DEPTH_C) || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        num_blocks_d  = num_blocks_q;
        blocks_done_d = blocks_done_q;
        overflow_d    = overflow_q || (push && !push_ok);
        timeout_err_d = timeout_err_q;
        byte_cnt_d    = push ? byte_cnt_q + 10'd1 : byte_cnt_q;
        wdog_d        = in_block ? wdog_q + WW'(1) : wdog_q;
        blocks_next   = blocks_done_q + 16'd1;
        rd_req        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d     = base_addr;
                    num_blocks_d  = num_blocks;
                    blocks_done_d = 16'd0;
                    overflow_d    = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (count_q <= SPACE_MAX) begin
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rd_req     = 1'b1;
                    byte_cnt_d = 10'd0;
                    wdog_d     = '0;
                    state_d    = S_READING;
                end
            end
            S_READING: begin
                // Short or long blocks are counted like full ones; only the reader knows its framing.
                if (rd_done) begin
                    blocks_done_d = blocks_next;
                    rd_addr_d     = rd_addr_q + 32'(ADDR_STEP);
                    if ((num_blocks_q != 16'd0) && (blocks_next == num_blocks_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end else if (wdog_q >= WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (abort) begin
                    state_d = S_DRAIN_ABORT;
                end
            end
            S_DRAIN_ABORT: begin
                if (rd_done) begin
                    state_d = S_IDLE;
                end else if (wdog_q >= WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_addr_q     <= 32'd0;
            num_blocks_q  <= 16'd0;
            blocks_done_q <= 16'd0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            byte_cnt_q    <= 10'd0;
            wdog_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            num_blocks_q  <= num_blocks_d;
            blocks_done_q <= blocks_done_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            byte_cnt_q    <= byte_cnt_d;
            wdog_q        <= wdog_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (push_ok && !rst) begin
            fifo_mem[wr_ptr_q] <= rd_data;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    assign busy        = (state_q != S_IDLE);
    assign blocks_done = blocks_done_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// tb/tb_sd_block_sequencer.sv - randomized self-checking bench for sd_block_sequencer
module tb_sd_block_sequencer;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst, start, abort, rd_valid, rd_done, out_ready;
    logic [31:0] base_addr;
    logic [15:0] num_blocks;
    logic [7:0]  rd_data;
    logic        rd_req, out_valid, busy, overflow, timeout_err;
    logic [31:0] rd_addr;
    logic [7:0]  out_data;
    logic [15:0] blocks_done;

    logic        t_start;
    logic        t_rd_req, t_out_valid, t_busy, t_overflow, t_timeout_err;
    logic [31:0] t_rd_addr;
    logic [7:0]  t_out_data;
    logic [15:0] t_blocks_done;

    sd_block_sequencer #(.FIFO_DEPTH(DEPTH), .ADDR_STEP(512), .TIMEOUT(2_000_000)) u_dut (
        .clk_25mhz(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_blocks(num_blocks), .abort(abort), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .blocks_done(blocks_done),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    sd_block_sequencer #(.FIFO_DEPTH(DEPTH), .ADDR_STEP(512), .TIMEOUT(100)) u_dut_to (
        .clk_25mhz(clk), .rst(rst), .start(t_start), .base_addr(32'h0000_7000),
        .num_blocks(16'd1), .abort(1'b0), .rd_req(t_rd_req), .rd_addr(t_rd_addr),
        .rd_data(8'h00), .rd_valid(1'b0), .rd_done(1'b0), .out_data(t_out_data),
        .out_valid(t_out_valid), .out_ready(1'b1), .busy(t_busy), .blocks_done(t_blocks_done),
        .overflow(t_overflow), .timeout_err(t_timeout_err)
    );

    int          n_checks = 0;
    int          n_err = 0;
    int          dut_pops = 0;
    int          w;
    logic [7:0]  q[$];
    bit          model_reading = 1'b0;
    bit          model_ovf = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: check FIFO head against the reference queue, then apply the edge to the queue.
    task automatic tick();
        bit pop, push;
        if (rand_ready) out_ready = 1'($urandom_range(1));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        if (out_valid && out_ready && !rst) dut_pops++;
        pop  = (q.size() != 0) && out_ready;
        push = rd_valid && model_reading;
        if (rst) begin
            q.delete();
            model_ovf = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(rd_data);
                else model_ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] num);
        base_addr = base; num_blocks = num; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_blocks_clr", 32'(blocks_done), 32'd0);
        chk("start_ovf_clr", 32'(overflow), 32'd0);
        chk("start_to_clr", 32'(timeout_err), 32'd0);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr, input int budget, output int waited);
        waited = 0;
        while (rd_req !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk("rd_req_seen", 32'(rd_req), 32'd1);
        chk("rd_addr", rd_addr, exp_addr);
        tick();
        chk("rd_req_one_cycle", 32'(rd_req), 32'd0);
        model_reading = 1'b1;
    endtask

    task automatic send_bytes(input int n, input int abort_at);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(3) == 0) tick();
            rd_valid = 1'b1;
            rd_data  = 8'($urandom);
            abort    = (i == abort_at);
            tick();
            rd_valid = 1'b0;
            abort    = 1'b0;
        end
    endtask

    task automatic end_block(input int exp_bd, input logic exp_busy);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        model_reading = 1'b0;
        chk("blocks_done", 32'(blocks_done), 32'(exp_bd));
        chk("busy_after_done", 32'(busy), 32'(exp_busy));
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("drained", 32'(out_valid), 32'd0);
    endtask

    task automatic watch_no_req(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (rd_req) seen++;
            tick();
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rbase;
        rst = 1'b1; start = 1'b0; abort = 1'b0; rd_valid = 1'b0; rd_done = 1'b0;
        out_ready = 1'b0; base_addr = '0; num_blocks = '0; rd_data = '0; t_start = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_blocks", 32'(blocks_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle_ignored", 32'(busy), 32'd0);

        // Two blocks, consumer always ready; a stray start mid-block must be ignored.
        out_ready = 1'b1; dut_pops = 0;
        do_start(32'h0000_1000, 16'd2);
        wait_req(32'h0000_1000, 20, w);
        send_bytes(100, -1);
        base_addr = 32'hDEAD_0000; num_blocks = 16'd1; start = 1'b1; tick(); start = 1'b0;
        send_bytes(412, -1);
        end_block(1, 1'b1);
        wait_req(32'h0000_1200, 20, w);
        send_bytes(512, -1);
        end_block(2, 1'b0);
        drain();
        chk("a_bytes_out", 32'(dut_pops), 32'd1024);
        chk("a_next_addr", rd_addr, 32'h0000_1400);

        // Three blocks with a stalled consumer; the address also wraps through zero.
        out_ready = 1'b0;
        do_start(32'hFFFF_FE00, 16'd3);
        wait_req(32'hFFFF_FE00, 20, w);
        send_bytes(512, -1);
        end_block(1, 1'b1);
        wait_req(32'h0000_0000, 20, w);
        send_bytes(512, -1);
        end_block(2, 1'b1);
        watch_no_req("b_no_third_req", 64);
        chk("b_busy_waiting", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_req(32'h0000_0200, 2000, w);
        chk("b_wait_for_space", 32'(w >= 512), 32'd1);
        rand_ready = 1'b1;
        send_bytes(512, -1);
        end_block(3, 1'b0);
        chk("b_no_overflow", 32'(overflow), 32'd0);
        drain();

        // Overfill inside one long block, then a push that meets a pop while full.
        out_ready = 1'b0;
        do_start(32'h0000_4000, 16'd1);
        wait_req(32'h0000_4000, 20, w);
        send_bytes(1024, -1);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        send_bytes(1025, -1);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_model", 32'(overflow), 32'(model_ovf));
        rd_valid = 1'b1; rd_data = 8'($urandom); out_ready = 1'b1;
        tick();
        rd_valid = 1'b0; out_ready = 1'b0;
        end_block(1, 1'b0);
        dut_pops = 0;
        drain();
        chk("ovf_full_count", 32'(dut_pops), 32'd1024);

        // Abort while waiting for space, then abort mid-block in continuous mode.
        do_start(32'h0000_9000, 16'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_wait_idle", 32'(busy), 32'd0);
        watch_no_req("abort_wait_no_req", 8);
        rbase = $urandom;
        rand_ready = 1'b1;
        do_start(rbase, 16'd0);
        wait_req(rbase, 20, w);
        send_bytes(512, 200);
        chk("c_draining_busy", 32'(busy), 32'd1);
        end_block(0, 1'b0);
        watch_no_req("c_no_req_after_abort", 50);
        drain();

        // Watchdog on the short-timeout instance.
        t_start = 1'b1; tick(); t_start = 1'b0;
        w = 0;
        while (t_rd_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("t_rd_req", 32'(t_rd_req), 32'd1);
        chk("t_rd_addr", t_rd_addr, 32'h0000_7000);
        tick();
        repeat (99) tick();
        chk("t_busy_before", 32'(t_busy), 32'd1);
        chk("t_to_before", 32'(t_timeout_err), 32'd0);
        tick();
        chk("t_busy_after", 32'(t_busy), 32'd0);
        chk("t_to_after", 32'(t_timeout_err), 32'd1);
        chk("t_blocks", 32'(t_blocks_done), 32'd0);
        chk("t_fifo_empty", 32'({t_out_valid, t_overflow, t_out_data}), 32'd0);
        t_start = 1'b1; tick(); t_start = 1'b0;
        chk("t_to_cleared", 32'(t_timeout_err), 32'd0);

        // Reset in the middle of a block; later strobes must not reach the FIFO.
        out_ready = 1'b0;
        do_start(32'h0000_8000, 16'd1);
        wait_req(32'h0000_8000, 20, w);
        send_bytes(100, -1);
        rst = 1'b1; rd_valid = 1'b1; rd_data = 8'hA5;
        tick();
        rst = 1'b0; rd_valid = 1'b0; model_reading = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rd_req", 32'(rd_req), 32'd0);
        chk("mrst_rd_addr", rd_addr, 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_blocks", 32'(blocks_done), 32'd0);
        chk("mrst_flags", 32'({overflow, timeout_err}), 32'd0);
        send_bytes(50, -1);
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("mrst_late_bytes", 32'(out_valid), 32'd0);
        chk("mrst_late_blocks", 32'(blocks_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
